// File: rtl/demux_dispatcher_if.sv
// Upstream handshake and demux-side bus of the nibble demux dispatcher.
// The slave modport is the dispatcher; the master modport is whoever drives it.
interface demux_dispatcher_if;
    logic [3:0] InData;
    logic [1:0] InDest;
    logic       InValid;
    logic       InReady;
    logic       RoundRobin;
    logic [3:0] Data;
    logic [1:0] Sel;
    logic [3:0] Enable;
    logic       Busy;
    logic [7:0] CountA;
    logic [7:0] CountB;
    logic [7:0] CountC;
    logic [7:0] CountD;

    modport slave (
        input  InData, InDest, InValid, RoundRobin,
        output InReady, Data, Sel, Enable, Busy, CountA, CountB, CountC, CountD
    );

    modport master (
        output InData, InDest, InValid, RoundRobin,
        input  InReady, Data, Sel, Enable, Busy, CountA, CountB, CountC, CountD
    );
endinterface

// File: rtl/demux_dispatcher.sv
// Buffers 4-bit words in a 2-deep FIFO and presents each on the demux inputs
// for DWELL cycles; per-channel saturating counters track dispatched words.
module dd_sat_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    output logic [7:0] o_cnt
);
    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_cnt <= '0;
        else if (i_inc && r_cnt != 8'hFF)  r_cnt <= r_cnt + 8'd1;
    end

    assign o_cnt = r_cnt;
endmodule

module demux_dispatcher #(
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_dispatcher_if.slave     bus
);
    typedef enum logic {S_IDLE, S_PRESENT} state_t;

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

    logic [5:0] r_mem [2];
    logic       r_wr;
    logic       r_rd;
    logic [1:0] r_cnt;
    logic [1:0] r_rr;
    state_t     r_state;
    logic [7:0] r_dwell;
    logic [3:0] r_data;
    logic [1:0] r_sel;
    logic [3:0] r_en;
    logic       r_busy;

    logic       w_ready;
    logic       w_push;
    logic       w_pop;
    logic [5:0] w_head;
    logic [7:0] w_cnt [4];

    // Ready looks only at occupancy, so a same-cycle pop never raises it.
    assign w_ready = (r_cnt != 2'd2);
    assign w_push  = bus.InValid && w_ready;
    assign w_head  = r_mem[r_rd];
    // Pop uses the pre-edge count: a word landing in an empty FIFO waits one edge.
    assign w_pop   = (r_cnt != 2'd0) && ((r_state == S_IDLE) || (r_dwell == 8'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_cnt    <= '0;
            r_rr     <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= {bus.InData, (bus.RoundRobin ? r_rr : bus.InDest)};
                r_wr        <= ~r_wr;
                if (bus.RoundRobin) r_rr <= r_rr + 2'd1;
            end
            if (w_pop) r_rd <= ~r_rd;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_dwell <= '0;
            r_data  <= '0;
            r_sel   <= '0;
            r_en    <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_PRESENT;
                        r_dwell <= DWELL_M1;
                        r_data  <= w_head[5:2];
                        r_sel   <= w_head[1:0];
                        r_en    <= 4'hF;
                        r_busy  <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (r_dwell != 8'd0) begin
                        r_dwell <= r_dwell - 8'd1;
                    end else if (w_pop) begin
                        r_dwell <= DWELL_M1;
                        r_data  <= w_head[5:2];
                        r_sel   <= w_head[1:0];
                    end else begin
                        // Sel is left on the last channel so the demux select stays quiet.
                        r_state <= S_IDLE;
                        r_data  <= '0;
                        r_en    <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        dd_sat_cnt u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .i_inc (w_pop && (w_head[1:0] == 2'(g))),
            .o_cnt (w_cnt[g])
        );
    end

    assign bus.InReady = w_ready;
    assign bus.Data    = r_data;
    assign bus.Sel     = r_sel;
    assign bus.Enable  = r_en;
    assign bus.Busy    = r_busy;
    assign bus.CountA  = w_cnt[0];
    assign bus.CountB  = w_cnt[1];
    assign bus.CountC  = w_cnt[2];
    assign bus.CountD  = w_cnt[3];
endmodule

// File: tb/tb_demux_dispatcher.sv
// Drives a DWELL=4 and a DWELL=1 dispatcher with shared stimulus and checks both
// against a queue-based reference model every cycle.
module tb_demux_dispatcher;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] t_data = '0;
    logic [1:0] t_dest = '0;
    logic       t_valid = 1'b0;
    logic       t_rr = 1'b0;

    demux_dispatcher_if bus4 ();
    demux_dispatcher_if bus1 ();

    assign bus4.InData = t_data;  assign bus1.InData = t_data;
    assign bus4.InDest = t_dest;  assign bus1.InDest = t_dest;
    assign bus4.InValid = t_valid; assign bus1.InValid = t_valid;
    assign bus4.RoundRobin = t_rr; assign bus1.RoundRobin = t_rr;

    demux_dispatcher #(.DWELL(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    demux_dispatcher #(.DWELL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic [3:0] o_data [2];
    logic [1:0] o_sel  [2];
    logic [3:0] o_en   [2];
    logic       o_busy [2];
    logic       o_rdy  [2];
    logic [7:0] o_cnt  [2][4];

    assign o_data[0] = bus4.Data;   assign o_data[1] = bus1.Data;
    assign o_sel[0]  = bus4.Sel;    assign o_sel[1]  = bus1.Sel;
    assign o_en[0]   = bus4.Enable; assign o_en[1]   = bus1.Enable;
    assign o_busy[0] = bus4.Busy;   assign o_busy[1] = bus1.Busy;
    assign o_rdy[0]  = bus4.InReady; assign o_rdy[1] = bus1.InReady;
    assign o_cnt[0][0] = bus4.CountA; assign o_cnt[0][1] = bus4.CountB;
    assign o_cnt[0][2] = bus4.CountC; assign o_cnt[0][3] = bus4.CountD;
    assign o_cnt[1][0] = bus1.CountA; assign o_cnt[1][1] = bus1.CountB;
    assign o_cnt[1][2] = bus1.CountC; assign o_cnt[1][3] = bus1.CountD;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: a word queue plus "cycles left on screen" per instance.
    int m_dw   [2];
    int m_q    [2][2];
    int m_n    [2];
    int m_rr   [2];
    bit m_pres [2];
    int m_left [2];
    int m_dat  [2];
    int m_sel  [2];
    int m_cnt  [2][4];
    bit m_push [2];

    function automatic string nm(input string tag, input int k);
        return {tag, (k == 0) ? "_d4" : "_d1"};
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_n[k] = 0; m_rr[k] = 0; m_pres[k] = 0; m_left[k] = 0;
            m_dat[k] = 0; m_sel[k] = 0; m_push[k] = 0;
            for (int c = 0; c < 4; c++) m_cnt[k][c] = 0;
        end
    endtask

    task automatic m_edge(input int k);
        int e;
        if (m_n[k] > 0 && (!m_pres[k] || m_left[k] == 1)) begin
            e = m_q[k][0];
            m_q[k][0] = m_q[k][1];
            m_n[k]--;
            m_dat[k] = e / 4;
            m_sel[k] = e % 4;
            m_pres[k] = 1;
            m_left[k] = m_dw[k];
            if (m_cnt[k][m_sel[k]] < 255) m_cnt[k][m_sel[k]]++;
        end else if (m_pres[k]) begin
            if (m_left[k] > 1) m_left[k]--;
            else begin m_pres[k] = 0; m_dat[k] = 0; end
        end
        if (m_push[k]) begin
            m_q[k][m_n[k]] = int'(t_data) * 4 + (t_rr ? m_rr[k] : int'(t_dest));
            m_n[k]++;
            if (t_rr) m_rr[k] = (m_rr[k] + 1) % 4;
        end
    endtask

    task automatic cmp_outs(input int k);
        chk(nm("data", k), int'(o_data[k]), m_dat[k]);
        chk(nm("sel", k),  int'(o_sel[k]),  m_sel[k]);
        chk(nm("en", k),   int'(o_en[k]),   m_pres[k] ? 15 : 0);
        chk(nm("busy", k), int'(o_busy[k]), int'(m_pres[k]));
        for (int c = 0; c < 4; c++) chk(nm("cnt", k), int'(o_cnt[k][c]), m_cnt[k][c]);
    endtask

    // One clock: check ready, advance the model across the edge, check outputs.
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            chk(nm("rdy", k), int'(o_rdy[k]), (m_n[k] < 2) ? 1 : 0);
            m_push[k] = rst_n && t_valid && (m_n[k] < 2);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst_n) m_edge(k);
            cmp_outs(k);
        end
    endtask

    task automatic idle(input int n);
        t_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        t_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        m_reset();
        for (int k = 0; k < 2; k++) cmp_outs(k);
        #3;
        rst_n = 1'b1;
    endtask

    // Push n words into instance tgt as fast as its ready allows.
    task automatic push_words(input int tgt, input int n, input logic [3:0] d0,
                              input logic [1:0] dest, input logic rr, input logic inc);
        int done = 0;
        int budget = 0;
        while (done < n && budget < 5000) begin
            t_valid = 1'b1;
            t_data = inc ? d0 + 4'(done) : d0;
            t_dest = dest;
            t_rr = rr;
            step();
            if (m_push[tgt]) done++;
            budget++;
        end
        t_valid = 1'b0;
        if (done < n) chk("push_timeout", done, n);
    endtask

    initial begin
        int low_run;
        int max_low;
        m_dw[0] = 4;
        m_dw[1] = 1;
        m_reset();

        // Reset state, with a word offered during reset that must be dropped.
        t_valid = 1'b1; t_data = 4'h7;
        #2;
        for (int k = 0; k < 2; k++) begin
            cmp_outs(k);
            chk(nm("rdy_rst", k), int'(o_rdy[k]), 1);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) cmp_outs(k);
        t_valid = 1'b0;
        #3 rst_n = 1'b1;
        idle(2);

        // Single word to channel C.
        push_words(0, 1, 4'hA, 2'd2, 1'b0, 1'b0);
        idle(8);
        chk("single_countC", int'(bus4.CountC), 1);
        chk("single_countA", int'(bus4.CountA), 0);
        chk("single_en_off", int'(bus4.Enable), 0);

        // Round-robin with back-pressure.
        do_reset();
        push_words(0, 5, 4'h1, 2'd0, 1'b1, 1'b1);
        idle(25);
        chk("rr_countA", int'(bus4.CountA), 2);
        chk("rr_countB", int'(bus4.CountB), 1);
        chk("rr_countC", int'(bus4.CountC), 1);
        chk("rr_countD", int'(bus4.CountD), 1);

        // Throughput on the DWELL=1 instance.
        do_reset();
        low_run = 0; max_low = 0;
        for (int i = 0; i < 10; i++) begin
            t_valid = 1'b1; t_data = 4'(i); t_dest = 2'd3; t_rr = 1'b0;
            if (!o_rdy[1]) low_run++; else low_run = 0;
            if (low_run > max_low) max_low = low_run;
            step();
        end
        idle(6);
        chk("thr_countD", int'(bus1.CountD), 10);
        chk("thr_ready_low_le1", (max_low <= 1) ? 1 : 0, 1);

        // Saturation on channel B.
        do_reset();
        push_words(1, 300, 4'h5, 2'd1, 1'b0, 1'b0);
        idle(6);
        chk("sat_countB", int'(bus1.CountB), 255);
        chk("sat_countA", int'(bus1.CountA), 0);
        chk("sat_countD", int'(bus1.CountD), 0);

        // Mixed mode: pointer is not advanced by the explicit push.
        do_reset();
        push_words(0, 1, 4'h3, 2'd0, 1'b1, 1'b0);
        push_words(0, 1, 4'h4, 2'd2, 1'b0, 1'b0);
        push_words(0, 1, 4'h5, 2'd3, 1'b1, 1'b0);
        idle(16);
        chk("mix_countA", int'(bus4.CountA), 1);
        chk("mix_countB", int'(bus4.CountB), 1);
        chk("mix_countC", int'(bus4.CountC), 1);
        chk("mix_countD", int'(bus4.CountD), 0);

        // Asynchronous reset in the middle of a dwell with one word buffered.
        do_reset();
        push_words(0, 2, 4'h9, 2'd1, 1'b0, 1'b1);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("arst_en", int'(bus4.Enable), 0);
        chk("arst_data", int'(bus4.Data), 0);
        chk("arst_busy", int'(bus4.Busy), 0);
        chk("arst_rdy", int'(bus4.InReady), 1);
        for (int k = 0; k < 2; k++) cmp_outs(k);
        t_valid = 1'b1; t_data = 4'hE;
        step();
        t_valid = 1'b0;
        #3 rst_n = 1'b1;
        idle(6);
        chk("arst_idle_en", int'(bus4.Enable), 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            t_valid = ($urandom_range(0, 99) < 60);
            t_data = 4'($urandom);
            t_dest = 2'($urandom);
            t_rr = 1'($urandom);
            step();
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
